// File: rtl/vga_controller.sv
// 640x480@60 VGA timing generator with an 8-bar colour test pattern.
// Runs from the 50 MHz clock; a toggling pixel enable gives the 25 MHz pixel rate.
module vga_controller #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic clk,
    input  logic resetbutton,
    output logic VGA_RED,
    output logic VGA_GREEN,
    output logic VGA_BLUE,
    output logic VGA_HSYNC,
    output logic VGA_VSYNC
);

    localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] BAR_WIDTH = 10'(H_VISIBLE / 8);

    logic       pix_en_q;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       red_q, green_q, blue_q, hsync_q, vsync_q;
    logic       red_d, green_d, blue_d, hsync_d, vsync_d;
    logic       visible;
    logic [2:0] bar_idx;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Outputs are decoded from the current counters and registered, so sync
    // and colour share the same one-clock latency.
    always_comb begin
        visible = (h_q < H_VIS) && (v_q < V_VIS);
        bar_idx = 3'(h_q / BAR_WIDTH);
        hsync_d = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
        vsync_d = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
        red_d   = visible && bar_idx[2];
        green_d = visible && bar_idx[1];
        blue_d  = visible && bar_idx[0];
    end

    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            red_q    <= 1'b0;
            green_q  <= 1'b0;
            blue_q   <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
        end else begin
            pix_en_q <= !pix_en_q;
            h_q      <= h_d;
            v_q      <= v_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
        end
    end

    assign VGA_RED   = red_q;
    assign VGA_GREEN = green_q;
    assign VGA_BLUE  = blue_q;
    assign VGA_HSYNC = hsync_q;
    assign VGA_VSYNC = vsync_q;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: per-clock scoreboard plus sync/colour-bar timing tasks.
// Vertical timing is shortened so whole frames fit in a short run.
module tb_vga_controller;

    localparam int TV_VIS   = 8;
    localparam int TV_FRONT = 2;
    localparam int TV_SYNC  = 2;
    localparam int TV_BACK  = 3;
    localparam int HT       = 800;
    localparam int VT       = TV_VIS + TV_FRONT + TV_SYNC + TV_BACK;
    localparam logic [4:0] RST_VAL = 5'b00011;

    logic clk = 1'b0;
    logic resetbutton;
    logic VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    logic [4:0] exp_q[$];

    vga_controller #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(TV_VIS), .V_FRONT(TV_FRONT), .V_SYNC(TV_SYNC), .V_BACK(TV_BACK)
    ) dut (
        .clk(clk),
        .resetbutton(resetbutton),
        .VGA_RED(VGA_RED),
        .VGA_GREEN(VGA_GREEN),
        .VGA_BLUE(VGA_BLUE),
        .VGA_HSYNC(VGA_HSYNC),
        .VGA_VSYNC(VGA_VSYNC)
    );

    always #10 clk = ~clk;

    // Output after the k-th edge since release shows pixel floor((k-1)/2).
    function automatic logic [4:0] model(input int k);
        int p, h, v;
        logic [2:0] rgb;
        logic hs, vs;
        p   = (k - 1) / 2;
        h   = p % HT;
        v   = (p / HT) % VT;
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= TV_VIS + TV_FRONT && v < TV_VIS + TV_FRONT + TV_SYNC);
        rgb = (h < 640 && v < TV_VIS) ? 3'(h / 80) : 3'b000;
        return {rgb, hs, vs};
    endfunction

    always @(posedge clk) begin
        if (!resetbutton) begin
            edge_cnt = 0;
            exp_q.push_back(RST_VAL);
        end else begin
            edge_cnt = edge_cnt + 1;
            exp_q.push_back(model(edge_cnt));
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!resetbutton) e = RST_VAL;
            checks++;
            if ({VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC} !== e) begin
                errors++;
                $display("FAIL scoreboard edge=%0d got=%b expected=%b", edge_cnt,
                         {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC}, e);
            end
        end
    end

    task automatic test_reset();
        resetbutton = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC} !== RST_VAL) begin
                errors++;
                $display("FAIL reset_hold got=%b expected=%b",
                         {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC}, RST_VAL);
            end
        end
        #2 resetbutton = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({VGA_RED, VGA_GREEN, VGA_BLUE} !== 3'b000) begin
                errors++;
                $display("FAIL first_pixel edge=%0d rgb=%b expected=000", edge_cnt,
                         {VGA_RED, VGA_GREEN, VGA_BLUE});
            end
        end
    endtask

    task automatic test_colour_bars();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                int t;
                int budget;
                t = 160 * i + ((j == 0) ? 2 : (j == 1) ? 81 : 160);
                budget = 2000;
                while (edge_cnt < t && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                checks++;
                if (edge_cnt != t || {VGA_RED, VGA_GREEN, VGA_BLUE} !== 3'(i)) begin
                    errors++;
                    $display("FAIL colour_bar%0d edge=%0d (want %0d) rgb=%b expected=%b",
                             i, edge_cnt, t, {VGA_RED, VGA_GREEN, VGA_BLUE}, 3'(i));
                end
            end
        end
    endtask

    task automatic test_hsync();
        int f1 = -1, r1 = -1, f2 = -1;
        int budget = 6000;
        logic prev;
        prev = VGA_HSYNC;
        while (f2 < 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (prev && !VGA_HSYNC) begin
                checks++;
                if ({VGA_RED, VGA_GREEN, VGA_BLUE} !== 3'b000) begin
                    errors++;
                    $display("FAIL hsync_blank rgb=%b expected=000", {VGA_RED, VGA_GREEN, VGA_BLUE});
                end
                if (f1 < 0) f1 = edge_cnt;
                else f2 = edge_cnt;
            end
            if (!prev && VGA_HSYNC && r1 < 0) r1 = edge_cnt;
            prev = VGA_HSYNC;
        end
        checks++;
        if (f1 != 1313) begin
            errors++;
            $display("FAIL hsync_first_fall edge=%0d expected=1313", f1);
        end
        checks++;
        if (r1 - f1 != 192) begin
            errors++;
            $display("FAIL hsync_low_time clk=%0d expected=192", r1 - f1);
        end
        checks++;
        if (f2 - f1 != 1600) begin
            errors++;
            $display("FAIL hsync_period clk=%0d expected=1600", f2 - f1);
        end
    endtask

    task automatic test_vsync();
        int f1 = -1, r1 = -1, f2 = -1;
        int budget = 45000;
        logic prev;
        prev = VGA_VSYNC;
        while (f2 < 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (prev && !VGA_VSYNC) begin
                checks++;
                if ({VGA_RED, VGA_GREEN, VGA_BLUE} !== 3'b000) begin
                    errors++;
                    $display("FAIL vsync_blank rgb=%b expected=000", {VGA_RED, VGA_GREEN, VGA_BLUE});
                end
                if (f1 < 0) f1 = edge_cnt;
                else f2 = edge_cnt;
            end
            if (!prev && VGA_VSYNC && r1 < 0) r1 = edge_cnt;
            prev = VGA_VSYNC;
        end
        checks++;
        if (f1 != 2 * (TV_VIS + TV_FRONT) * HT + 1) begin
            errors++;
            $display("FAIL vsync_first_fall edge=%0d expected=%0d", f1, 2 * (TV_VIS + TV_FRONT) * HT + 1);
        end
        checks++;
        if (r1 - f1 != TV_SYNC * 1600) begin
            errors++;
            $display("FAIL vsync_low_time clk=%0d expected=%0d", r1 - f1, TV_SYNC * 1600);
        end
        checks++;
        if (f2 - f1 != VT * 1600) begin
            errors++;
            $display("FAIL vsync_period clk=%0d expected=%0d", f2 - f1, VT * 1600);
        end
    endtask

    task automatic test_mid_reset();
        int budget = 30000;
        int p;
        int hf = -1, vf = -1;
        logic hprev, vprev;
        p = (edge_cnt - 1) / 2;
        while (!(((p / HT) % VT) == 4 && (p % HT) == 300) && budget > 0) begin
            @(negedge clk);
            budget--;
            p = (edge_cnt - 1) / 2;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL mid_reset_reach line/pixel not reached edge=%0d", edge_cnt);
        end
        #2 resetbutton = 1'b0;
        #1;
        checks++;
        if ({VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC} !== RST_VAL) begin
            errors++;
            $display("FAIL mid_reset_immediate got=%b expected=%b",
                     {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC}, RST_VAL);
        end
        repeat (4) @(negedge clk);
        #2 resetbutton = 1'b1;
        hprev = VGA_HSYNC;
        vprev = VGA_VSYNC;
        budget = 20000;
        while (vf < 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (hprev && !VGA_HSYNC && hf < 0) hf = edge_cnt;
            if (vprev && !VGA_VSYNC) vf = edge_cnt;
            hprev = VGA_HSYNC;
            vprev = VGA_VSYNC;
        end
        checks++;
        if (hf != 1313) begin
            errors++;
            $display("FAIL mid_reset_hsync_fall edge=%0d expected=1313", hf);
        end
        checks++;
        if (vf != 2 * (TV_VIS + TV_FRONT) * HT + 1) begin
            errors++;
            $display("FAIL mid_reset_vsync_fall edge=%0d expected=%0d", vf, 2 * (TV_VIS + TV_FRONT) * HT + 1);
        end
    endtask

    initial begin
        resetbutton = 1'b0;
        test_reset();
        test_colour_bars();
        test_hsync();
        test_vsync();
        test_mid_reset();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
